// File: rtl/ucaspian_pkg.sv
// uCaspian synapse: shared widths, RAM entry layout and walk FSM states.
// Imported by the synapse interface, RAM and top.
package ucaspian_pkg;
  localparam int SYN_AW    = 12;
  localparam int NID_W     = 8;
  localparam int WGT_W     = 8;
  localparam int OUT_DEPTH = 2;
  localparam int SYN_DEPTH = 2 ** SYN_AW;

  typedef logic [SYN_AW-1:0] syn_addr_t;

  typedef struct packed {
    logic [NID_W-1:0]        id;
    logic signed [WGT_W-1:0] weight;
  } syn_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    CLEAR
  } syn_state_t;
endpackage

// File: rtl/ucaspian_synapse_if.sv
// Range-in / dendrite-out streams of the synapse block.
// master drives ranges and dend_rdy; slave is the synapse side.
interface ucaspian_synapse_if
  import ucaspian_pkg::*;
();
  syn_addr_t        syn_start;
  syn_addr_t        syn_end;
  logic             syn_vld;
  logic             syn_rdy;
  logic [NID_W-1:0] dend_id;
  logic [WGT_W-1:0] dend_weight;
  logic             dend_vld;
  logic             dend_rdy;

  modport master (
    output syn_start, syn_end, syn_vld,
    input  syn_rdy,
    input  dend_id, dend_weight, dend_vld,
    output dend_rdy
  );

  modport slave (
    input  syn_start, syn_end, syn_vld,
    output syn_rdy,
    output dend_id, dend_weight, dend_vld,
    input  dend_rdy
  );
endinterface

// File: rtl/dp_ram_16x4096.sv
// Synapse store: one write port, one registered read port.
// Read data appears the cycle after rd_en.
module dp_ram_16x4096
  import ucaspian_pkg::*;
(
  input  logic        clk,
  input  logic        rd_en,
  input  syn_addr_t   rd_addr,
  output logic [15:0] rd_data,
  input  logic        wr_en,
  input  syn_addr_t   wr_addr,
  input  logic [15:0] wr_data
);
  logic [15:0] mem [SYN_DEPTH];

  // write port owned by config / clear sweep
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // read port owned by the range walk
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/ucaspian_synapse.sv
// Synapse range walker: ranges in, (id, weight) stream out.
// Define UCASPIAN_SYN_SKIP_ZERO_EN to drop zero-weight entries.
module ucaspian_synapse
  import ucaspian_pkg::*;
#(
  parameter int OUT_DEPTH = ucaspian_pkg::OUT_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            clear_config,
  output logic            clear_done,
  input  syn_addr_t       config_addr,
  input  logic [7:0]      config_value,
  input  logic [2:0]      config_byte,
  input  logic            config_enable,
  input  logic            next_step,
  output logic            step_done,
  ucaspian_synapse_if.slave bus
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;

  syn_state_t  state, state_nx;
  syn_addr_t   cur, last, rd_addr;
  syn_addr_t   wr_addr, clr_addr;
  logic [15:0] rd_data, wr_data;
  syn_entry_t  rd_ent, stage, head;
  syn_entry_t  fifo [OUT_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [CW:0]   occ;
  logic rd_en, rd_vld, wr_en;
  logic live, clr_done_q, step_q;
  logic syn_rdy, hs, credit;
  logic push, pop, flush, dend_vld;

  assign rd_ent   = syn_entry_t'(rd_data);
  assign flush    = clear_config || state == CLEAR;
  assign dend_vld = cnt != '0;
  assign pop      = dend_vld && bus.dend_rdy;
  assign hs       = bus.syn_vld && syn_rdy;
  assign occ      = {1'b0, cnt} + (CW+1)'(rd_vld)
                  - (CW+1)'(pop);
  assign credit   = occ < (CW+1)'(OUT_DEPTH);

`ifdef UCASPIAN_SYN_SKIP_ZERO_EN
  assign push = rd_vld && !flush
             && rd_ent.weight != '0;
`else
  assign push = rd_vld && !flush;
`endif

  assign head            = fifo[rp];
  assign bus.syn_rdy     = syn_rdy;
  assign bus.dend_vld    = dend_vld;
  assign bus.dend_id     = dend_vld ? head.id : '0;
  assign bus.dend_weight = dend_vld ? head.weight : '0;
  assign clear_done      = clr_done_q;
  assign step_done       = step_q;

  dp_ram_16x4096 u_ram (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next state; clear overrides everything
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (hs && !(credit
            && bus.syn_start == bus.syn_end))
          state_nx = WALK;
      WALK:
        if (credit && cur == last) state_nx = IDLE;
      CLEAR:
        if (!clear_config) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear_config) state_nx = CLEAR;
  end

  // range accept and read issue; IDLE reads syn_start
  // at the handshake so consecutive ranges leave no gap
  always_comb begin
    syn_rdy = 1'b0;
    rd_en   = 1'b0;
    rd_addr = cur;
    unique case (state)
      IDLE: begin
        syn_rdy = live && enable && !clear_config;
        rd_en   = hs && credit;
        rd_addr = bus.syn_start;
      end
      WALK: rd_en = credit && !clear_config;
      default: ;
    endcase
  end

  // walk pointers and out-of-reset flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur    <= '0;
      last   <= '0;
      live   <= 1'b0;
      rd_vld <= 1'b0;
    end else begin
      live   <= 1'b1;
      rd_vld <= rd_en && !flush;
      if (state == IDLE && hs) begin
        cur  <= rd_en ? bus.syn_start + syn_addr_t'(1)
                      : bus.syn_start;
        last <= bus.syn_end;
      end else if (state == WALK && rd_en) begin
        cur  <= cur + syn_addr_t'(1);
      end
    end
  end

  // output FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // output FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= rd_ent;
  end

  // clear sweep counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_addr   <= '0;
      clr_done_q <= 1'b0;
    end else if (state == CLEAR && clear_config) begin
      if (!clr_done_q) begin
        clr_addr <= clr_addr + syn_addr_t'(1);
        if (clr_addr == '1) clr_done_q <= 1'b1;
      end
    end else begin
      clr_addr   <= '0;
      clr_done_q <= 1'b0;
    end
  end

  // config staging register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage <= '0;
    end else if (config_enable) begin
      unique case (config_byte)
        3'd1: stage        <= '0;
        3'd2: stage.id     <= config_value;
        3'd3: stage.weight <= config_value;
        default: ;
      endcase
    end
  end

  // write port: sweep in CLEAR, else config byte 3
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = config_addr;
    wr_data = {stage.id, config_value};
    if (state == CLEAR) begin
      wr_en   = clear_config && !clr_done_q;
      wr_addr = clr_addr;
      wr_data = '0;
    end else if (config_enable
                 && config_byte == 3'd3) begin
      wr_en = 1'b1;
    end
  end

  // registered idle indication for time sync
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= !next_step
                       && state == IDLE
                       && !bus.syn_vld
                       && cnt == '0
                       && !rd_vld
                       && !clear_config;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset)
    !(push && !pop && cnt == CW'(OUT_DEPTH)));
endmodule
